// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown front-panel editor.
// Digit order everywhere is sec_1 (index 0) up to hr_10 (index 5).
package countdown_pkg;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam logic [3:0] FILL_NIBBLE = 4'hF;
    localparam logic [3:0] DIGIT_MAX [0:NUM_DIGITS-1] = '{4'd9, 4'd5, 4'd9, 4'd5, 4'd9, 4'd9};

    localparam logic [2:0] CUR_SEC_1  = 3'd0;
    localparam logic [2:0] CUR_SEC_10 = 3'd1;
    localparam logic [2:0] CUR_MIN_1  = 3'd2;
    localparam logic [2:0] CUR_MIN_10 = 3'd3;
    localparam logic [2:0] CUR_HR_1   = 3'd4;
    localparam logic [2:0] CUR_HR_10  = 3'd5;

    // Bit positions of the buttons inside the packed press vector.
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_START = 4;

    // Wrapping single-digit step in either direction.
    function automatic logic [3:0] digit_step(input logic [3:0] value,
                                              input logic [3:0] max_value,
                                              input logic       up);
        if (up) begin
            return (value == max_value) ? 4'd0 : value + 4'd1;
        end
        return (value == 4'd0) ? max_value : value - 4'd1;
    endfunction

endpackage

// File: rtl/countdown_setter_if.sv
// Link between the setter (master) and the countdown core (slave).
interface countdown_setter_if;

    logic [31:0] time_set;
    logic        go;
    logic        finish;

    modport master (output time_set, output go, input finish);
    modport slave  (input time_set, input go, output finish);

endinterface

// File: rtl/button_debounce.sv
// Synchronises one raw push-button, debounces it and emits a 1-cycle pulse
// on each accepted press (no auto-repeat while held).
module button_debounce #(
    parameter int DB_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_stable,
    output logic btn_press
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync_meta;
    logic          sync_out;
    logic [CW-1:0] count;

    // The counter only runs while the synchronised input disagrees with the
    // accepted value, so any bounce back restarts the qualification window.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_out   <= 1'b0;
            count      <= '0;
            btn_stable <= 1'b0;
            btn_press  <= 1'b0;
        end else begin
            sync_meta <= btn_raw;
            sync_out  <= sync_meta;
            btn_press <= 1'b0;
            if (sync_out == btn_stable) begin
                count <= '0;
            end else if (count == CW'(DB_CYCLES - 1)) begin
                count      <= '0;
                btn_stable <= sync_out;
                btn_press  <= sync_out;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/countdown_setter.sv
// Front-panel editor and run control: edits a 6-digit BCD preset with a
// cursor, starts/aborts the countdown and acknowledges its finish flag.
module countdown_setter
    import countdown_pkg::*;
#(
    parameter int          DB_CYCLES    = 2_000_000,
    parameter int          BLINK_HALF   = 25_000_000,
    parameter logic [31:0] DEFAULT_TIME = 32'h00F01F00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_start,
    countdown_setter_if.master cd,
    output logic [2:0]         cursor,
    output logic               blink,
    output logic               editing
);

    localparam int BW = $clog2(BLINK_HALF + 1);

    state_t        state;
    state_t        state_next;
    logic [3:0]    digit [0:NUM_DIGITS-1];
    logic [4:0]    btn_raw;
    logic [4:0]    press;
    logic          act_start;
    logic          act_up;
    logic          act_down;
    logic          act_left;
    logic          act_right;
    logic          all_zero;
    logic          fin_meta;
    logic          fin_sync;
    logic [BW-1:0] blink_count;
    logic          blink_phase;

    assign btn_raw = {btn_start, btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < 5; i++) begin : g_db
        button_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk        (clk),
            .rst        (rst),
            .btn_raw    (btn_raw[i]),
            .btn_stable (),
            .btn_press  (press[i])
        );
    end

    // finish comes from the countdown's slow clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            fin_meta <= 1'b0;
            fin_sync <= 1'b0;
        end else begin
            fin_meta <= cd.finish;
            fin_sync <= fin_meta;
        end
    end

    assign all_zero = ((digit[0] | digit[1] | digit[2] |
                        digit[3] | digit[4] | digit[5]) == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EDIT;
        end else begin
            state <= state_next;
        end
    end

    // Only the highest-priority press of a cycle survives.
    always_comb begin
        act_start  = press[BTN_START];
        act_up     = press[BTN_UP]    & ~press[BTN_START];
        act_down   = press[BTN_DOWN]  & ~(|press[BTN_START:BTN_UP]);
        act_left   = press[BTN_LEFT]  & ~(|press[BTN_START:BTN_DOWN]);
        act_right  = press[BTN_RIGHT] & ~(|press[BTN_START:BTN_LEFT]);
        state_next = state;
        case (state)
            EDIT: if (act_start && !all_zero) state_next = RUN;
            RUN: begin
                if (fin_sync)       state_next = DONE;
                else if (act_start) state_next = EDIT;
            end
            DONE: if (act_start) state_next = EDIT;
            default: state_next = EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit[0] <= DEFAULT_TIME[3:0];
            digit[1] <= DEFAULT_TIME[7:4];
            digit[2] <= DEFAULT_TIME[15:12];
            digit[3] <= DEFAULT_TIME[19:16];
            digit[4] <= DEFAULT_TIME[27:24];
            digit[5] <= DEFAULT_TIME[31:28];
            cursor   <= CUR_SEC_1;
        end else if (state == EDIT) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (cursor == 3'(i)) begin
                    if (act_up) begin
                        digit[i] <= digit_step(digit[i], DIGIT_MAX[i], 1'b1);
                    end else if (act_down) begin
                        digit[i] <= digit_step(digit[i], DIGIT_MAX[i], 1'b0);
                    end
                end
            end
            if (act_left) begin
                cursor <= (cursor == CUR_HR_10) ? CUR_SEC_1 : cursor + 3'd1;
            end else if (act_right) begin
                cursor <= (cursor == CUR_SEC_1) ? CUR_HR_10 : cursor - 3'd1;
            end
        end
    end

    // Held cleared outside EDIT, so each entry to EDIT restarts the blink.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_count <= '0;
            blink_phase <= 1'b1;
        end else if (state != EDIT) begin
            blink_count <= '0;
            blink_phase <= 1'b1;
        end else if (blink_count == BW'(BLINK_HALF - 1)) begin
            blink_count <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_count <= blink_count + BW'(1);
        end
    end

    assign cd.time_set = {digit[5], digit[4], FILL_NIBBLE, digit[3],
                          digit[2], FILL_NIBBLE, digit[1], digit[0]};
    assign cd.go       = (state != EDIT);
    assign editing     = (state == EDIT);
    assign blink       = (state == EDIT) ? blink_phase : 1'b1;

endmodule

// File: tb/tb_countdown_setter.sv
// Directed bench for countdown_setter with short debounce and blink periods.
module tb_countdown_setter;

    localparam logic [4:0] B_START = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_start = 1'b0;
    logic [2:0] cursor;
    logic       blink;
    logic       editing;
    int         compared = 0;
    int         failed = 0;

    countdown_setter_if bus ();

    countdown_setter #(
        .DB_CYCLES    (4),
        .BLINK_HALF   (8),
        .DEFAULT_TIME (32'h00F01F00)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_start (btn_start),
        .cd        (bus),
        .cursor    (cursor),
        .blink     (blink),
        .editing   (editing)
    );

    always #5 clk = ~clk;

    task automatic press(input logic [4:0] mask, input int hold);
        @(negedge clk);
        {btn_start, btn_up, btn_down, btn_left, btn_right} = mask;
        repeat (hold) @(negedge clk);
        {btn_start, btn_up, btn_down, btn_left, btn_right} = 5'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic press_n(input logic [4:0] mask, input int n);
        for (int k = 0; k < n; k++) press(mask, 12);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        compared++; if (bus.time_set !== 32'h00F01F00) begin failed++; $display("[TB] FAIL reset_time: got %h expected %h", bus.time_set, 32'h00F01F00); end
        compared++; if (bus.go !== 1'b0) begin failed++; $display("[TB] FAIL reset_go: got %b expected 0", bus.go); end
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL reset_cursor: got %0d expected 0", cursor); end
        compared++; if (blink !== 1'b1) begin failed++; $display("[TB] FAIL reset_blink: got %b expected 1", blink); end
        compared++; if (editing !== 1'b1) begin failed++; $display("[TB] FAIL reset_editing: got %b expected 1", editing); end
        repeat (7) @(negedge clk);
        compared++; if (blink !== 1'b1) begin failed++; $display("[TB] FAIL blink_before_toggle: got %b expected 1", blink); end
        @(negedge clk);
        compared++; if (blink !== 1'b0) begin failed++; $display("[TB] FAIL blink_toggle: got %b expected 0", blink); end
    endtask

    task automatic test_increment();
        press_n(B_UP, 3);
        compared++; if (bus.time_set !== 32'h00F01F03) begin failed++; $display("[TB] FAIL inc_time: got %h expected %h", bus.time_set, 32'h00F01F03); end
        compared++; if (bus.go !== 1'b0) begin failed++; $display("[TB] FAIL inc_go: got %b expected 0", bus.go); end
    endtask

    task automatic test_wrap();
        press(B_LEFT, 12);
        compared++; if (cursor !== 3'd1) begin failed++; $display("[TB] FAIL wrap_cursor1: got %0d expected 1", cursor); end
        press(B_DOWN, 12);
        compared++; if (bus.time_set !== 32'h00F01F53) begin failed++; $display("[TB] FAIL sec10_down_wrap: got %h expected %h", bus.time_set, 32'h00F01F53); end
        press(B_UP, 12);
        compared++; if (bus.time_set !== 32'h00F01F03) begin failed++; $display("[TB] FAIL sec10_up_wrap: got %h expected %h", bus.time_set, 32'h00F01F03); end
        press(B_RIGHT, 12);
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL wrap_cursor0: got %0d expected 0", cursor); end
        press_n(B_DOWN, 3);
        compared++; if (bus.time_set !== 32'h00F01F00) begin failed++; $display("[TB] FAIL sec1_down: got %h expected %h", bus.time_set, 32'h00F01F00); end
        press(B_DOWN, 12);
        compared++; if (bus.time_set !== 32'h00F01F09) begin failed++; $display("[TB] FAIL sec1_down_wrap: got %h expected %h", bus.time_set, 32'h00F01F09); end
    endtask

    task automatic test_edge_cases();
        @(negedge clk);
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        compared++; if (bus.time_set !== 32'h00F01F09) begin failed++; $display("[TB] FAIL glitch_ignored: got %h expected %h", bus.time_set, 32'h00F01F09); end
        press(B_UP, 40);
        compared++; if (bus.time_set !== 32'h00F01F00) begin failed++; $display("[TB] FAIL no_autorepeat: got %h expected %h", bus.time_set, 32'h00F01F00); end
        press(B_UP | B_LEFT, 12);
        compared++; if (bus.time_set !== 32'h00F01F01) begin failed++; $display("[TB] FAIL simul_digit: got %h expected %h", bus.time_set, 32'h00F01F01); end
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL simul_cursor: got %0d expected 0", cursor); end
        press(B_RIGHT, 12);
        compared++; if (cursor !== 3'd5) begin failed++; $display("[TB] FAIL right_wrap: got %0d expected 5", cursor); end
        press(B_LEFT, 12);
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL left_wrap: got %0d expected 0", cursor); end
    endtask

    task automatic test_start();
        press(B_DOWN, 12);
        press_n(B_LEFT, 2);
        press(B_DOWN, 12);
        compared++; if (bus.time_set !== 32'h00F00F00) begin failed++; $display("[TB] FAIL zero_preset: got %h expected %h", bus.time_set, 32'h00F00F00); end
        press(B_START, 12);
        compared++; if (bus.go !== 1'b0) begin failed++; $display("[TB] FAIL zero_start_go: got %b expected 0", bus.go); end
        compared++; if (editing !== 1'b1) begin failed++; $display("[TB] FAIL zero_start_editing: got %b expected 1", editing); end
        press_n(B_RIGHT, 2);
        press_n(B_UP, 5);
        compared++; if (bus.time_set !== 32'h00F00F05) begin failed++; $display("[TB] FAIL preset_5s: got %h expected %h", bus.time_set, 32'h00F00F05); end
        press(B_START, 12);
        compared++; if (bus.go !== 1'b1) begin failed++; $display("[TB] FAIL run_go: got %b expected 1", bus.go); end
        compared++; if (editing !== 1'b0) begin failed++; $display("[TB] FAIL run_editing: got %b expected 0", editing); end
        compared++; if (blink !== 1'b1) begin failed++; $display("[TB] FAIL run_blink: got %b expected 1", blink); end
        press_n(B_UP, 2);
        compared++; if (bus.time_set !== 32'h00F00F05) begin failed++; $display("[TB] FAIL run_frozen_time: got %h expected %h", bus.time_set, 32'h00F00F05); end
        press(B_LEFT, 12);
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL run_frozen_cursor: got %0d expected 0", cursor); end
    endtask

    task automatic test_finish();
        @(negedge clk);
        bus.finish = 1'b1;
        repeat (6) @(negedge clk);
        compared++; if (bus.go !== 1'b1) begin failed++; $display("[TB] FAIL done_go: got %b expected 1", bus.go); end
        compared++; if (editing !== 1'b0) begin failed++; $display("[TB] FAIL done_editing: got %b expected 0", editing); end
        bus.finish = 1'b0;
        repeat (4) @(negedge clk);
        press(B_START, 12);
        compared++; if (bus.go !== 1'b0) begin failed++; $display("[TB] FAIL ack_go: got %b expected 0", bus.go); end
        compared++; if (editing !== 1'b1) begin failed++; $display("[TB] FAIL ack_editing: got %b expected 1", editing); end
        compared++; if (bus.time_set !== 32'h00F00F05) begin failed++; $display("[TB] FAIL ack_time: got %h expected %h", bus.time_set, 32'h00F00F05); end
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL ack_cursor: got %0d expected 0", cursor); end
    endtask

    task automatic test_reset_in_run();
        press_n(B_LEFT, 3);
        compared++; if (cursor !== 3'd3) begin failed++; $display("[TB] FAIL pre_run_cursor: got %0d expected 3", cursor); end
        press(B_START, 12);
        compared++; if (bus.go !== 1'b1) begin failed++; $display("[TB] FAIL rerun_go: got %b expected 1", bus.go); end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (bus.go !== 1'b0) begin failed++; $display("[TB] FAIL rst_run_go: got %b expected 0", bus.go); end
        compared++; if (bus.time_set !== 32'h00F01F00) begin failed++; $display("[TB] FAIL rst_run_time: got %h expected %h", bus.time_set, 32'h00F01F00); end
        compared++; if (cursor !== 3'd0) begin failed++; $display("[TB] FAIL rst_run_cursor: got %0d expected 0", cursor); end
        compared++; if (editing !== 1'b1) begin failed++; $display("[TB] FAIL rst_run_editing: got %b expected 1", editing); end
        rst = 1'b0;
    endtask

    initial begin
        bus.finish = 1'b0;
        $display("[TB] countdown_setter bench starting");
        test_reset();
        test_increment();
        test_wrap();
        test_edge_cases();
        test_start();
        test_finish();
        test_reset_in_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
